sm2_kdf_ctrl: RTL and testbench

SM2_KDF_CTRL -- requirements
Module: sm2_kdf_ctrl

---
 rtl/sm2_kdf_ctrl_if.sv | 28 ++
 rtl/sm2_kdf_ctrl.sv | 87 ++++++++
 tb/tb_sm2_kdf_ctrl.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/sm2_kdf_ctrl_if.sv
// Handshake bundle between the SM2 KDF controller, its requester and the shared SM3 engine.
// The slave modport is the controller side; master is the environment (requester + SM3 engine).
interface sm2_kdf_ctrl_if #(
    parameter int ZLEN = 512,
    parameter int KLEN = 152
);
    logic              start;
    logic              abort;
    logic [ZLEN-1:0]   z;
    logic              hash_req;
    logic [ZLEN+31:0]  hash_msg;
    logic              hash_valid;
    logic [255:0]      hash_dig;
    logic              busy;
    logic              done;
    logic [KLEN-1:0]   k;
    logic              k_zero;

    modport slave (
        input  start, abort, z, hash_valid, hash_dig,
        output hash_req, hash_msg, busy, done, k, k_zero
    );

    modport master (
        output start, abort, z, hash_valid, hash_dig,
        input  hash_req, hash_msg, busy, done, k, k_zero
    );
endinterface

// File: rtl/sm2_kdf_ctrl.sv
// SM2 key-derivation sequencer: issues NBLK SM3 requests over {z, ct} and assembles the key.
//
// state  | meaning
// IDLE   | waiting for start; k/k_zero hold last result
// REQ    | one-cycle hash_req for the current ct
// WAIT   | waiting for the digest of the current ct
// DONE   | one-cycle done pulse, key valid
module sm2_kdf_ctrl #(
    parameter int ZLEN = 512,
    parameter int KLEN = 152
) (
    input  logic clk,
    input  logic rst_n,
    sm2_kdf_ctrl_if.slave bus
);
    localparam int NBLK = (KLEN + 255) / 256;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]      state;
    logic [31:0]     ct;
    logic [ZLEN-1:0] z_reg;
    logic [KLEN-1:0] k_reg;
    logic [KLEN-1:0] k_next;
    logic            k_done;

    // Each key bit belongs to block (KLEN-1-i)/256; the final block keeps only the top LAST digest bits.
    always_comb begin
        k_next = k_reg;
        for (int i = 0; i < KLEN; i++) begin
            if (32'((KLEN - 1 - i) / 256) == ct - 32'd1)
                k_next[i] = bus.hash_dig[255 - ((KLEN - 1 - i) % 256)];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            ct     <= '0;
            z_reg  <= '0;
            k_reg  <= '0;
            k_done <= 1'b0;
        end else if (bus.abort) begin
            state  <= S_IDLE;
            ct     <= '0;
            k_reg  <= '0;
            k_done <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        z_reg  <= bus.z;
                        ct     <= 32'd1;
                        k_reg  <= '0;
                        k_done <= 1'b0;
                        state  <= S_REQ;
                    end
                end
                S_REQ: state <= S_WAIT;
                S_WAIT: begin
                    if (bus.hash_valid) begin
                        k_reg <= k_next;
                        if (ct < 32'(NBLK)) begin
                            ct    <= ct + 32'd1;
                            state <= S_REQ;
                        end else begin
                            k_done <= 1'b1;
                            state  <= S_DONE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // k is exposed from the DONE cycle onward; k_done masks the partial key while blocks accumulate.
    assign bus.hash_req = (state == S_REQ);
    assign bus.hash_msg = {z_reg, ct};
    assign bus.busy     = (state != S_IDLE);
    assign bus.done     = (state == S_DONE);
    assign bus.k        = k_done ? k_reg : '0;
    assign bus.k_zero   = k_done && (k_reg == '0);
endmodule

// File: tb/tb_sm2_kdf_ctrl.sv
// Scoreboard bench for sm2_kdf_ctrl: one-key (KLEN=152) and two-block (KLEN=300) instances.
module tb_sm2_kdf_ctrl;
    localparam int ZLEN = 512;

    typedef struct {
        logic [299:0] k;
        logic         kz;
        int           cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_pass = 0;
    int   n_total = 0;

    exp_t q152[$];
    exp_t q300[$];
    exp_t e152, e300;

    bit          pend152 = 0, pend300 = 0;
    bit          stray152 = 0, stray300 = 0;
    bit          zero152 = 0;
    int          left152 = 1000, left300 = 1000;
    logic [31:0] msg152 = '0, msg300 = '0;
    logic [ZLEN-1:0] zpat;

    localparam logic [151:0] K152 = 152'h00000001_00000001_00000001_00000001_000000;
    localparam logic [299:0] K300 = {{8{32'h1}}, 44'h00000002000};

    sm2_kdf_ctrl_if #(.ZLEN(ZLEN), .KLEN(152)) bus152();
    sm2_kdf_ctrl_if #(.ZLEN(ZLEN), .KLEN(300)) bus300();

    sm2_kdf_ctrl #(.ZLEN(ZLEN), .KLEN(152)) u152 (.clk(clk), .rst_n(rst_n), .bus(bus152));
    sm2_kdf_ctrl #(.ZLEN(ZLEN), .KLEN(300)) u300 (.clk(clk), .rst_n(rst_n), .bus(bus300));

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Responders: answer one cycle after hash_req with {8{ct}} (or zeros), plus injectable stray strobes.
    always @(negedge clk) begin
        bus152.hash_valid = (pend152 && left152 > 0) || stray152;
        if (pend152 && left152 > 0) left152--;
        bus152.hash_dig = zero152 ? '0 : {8{msg152}};
        pend152 = (bus152.hash_req === 1'b1);
        msg152  = bus152.hash_msg[31:0];
    end

    always @(negedge clk) begin
        bus300.hash_valid = (pend300 && left300 > 0) || stray300;
        if (pend300 && left300 > 0) left300--;
        bus300.hash_dig = {8{msg300}};
        pend300 = (bus300.hash_req === 1'b1);
        msg300  = bus300.hash_msg[31:0];
    end

    // Monitors: every done must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (bus152.done === 1'b1) begin
            if (q152.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_done152: got done at cycle %0d expected none", cyc);
            end else begin
                e152 = q152.pop_front();
                chk("k152", 512'(bus152.k), 512'(e152.k));
                chk("kzero152", 512'(bus152.k_zero), 512'(e152.kz));
                chk("done_cyc152", 512'(cyc), 512'(e152.cyc));
            end
        end
        if (bus300.done === 1'b1) begin
            if (q300.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_done300: got done at cycle %0d expected none", cyc);
            end else begin
                e300 = q300.pop_front();
                chk("k300", 512'(bus300.k), 512'(e300.k));
                chk("kzero300", 512'(bus300.k_zero), 512'(e300.kz));
                chk("done_cyc300", 512'(cyc), 512'(e300.cyc));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start152(input logic [299:0] ek, input logic ekz, input bit push);
        exp_t e;
        bus152.start = 1'b1;
        bus152.z = zpat;
        e.k = ek; e.kz = ekz; e.cyc = cyc + 3;
        if (push) q152.push_back(e);
        tick();
        bus152.start = 1'b0;
    endtask

    task automatic start300(input logic [299:0] ek, input logic ekz, input bit push);
        exp_t e;
        bus300.start = 1'b1;
        bus300.z = zpat;
        e.k = ek; e.kz = ekz; e.cyc = cyc + 5;
        if (push) q300.push_back(e);
        tick();
        bus300.start = 1'b0;
    endtask

    initial begin
        bus152.start = 0; bus152.abort = 0; bus152.z = '0;
        bus300.start = 0; bus300.abort = 0; bus300.z = '0;
        zpat = {16{32'hDEADBEEF}};
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 512'(bus300.busy), 0);
        chk("rst_hash_req", 512'(bus300.hash_req), 0);
        chk("rst_hash_msg", 512'(bus300.hash_msg), 0);
        chk("rst_k", 512'(bus300.k), 0);
        chk("rst_k_zero", 512'(bus300.k_zero), 0);
        chk("rst_done", 512'(bus152.done), 0);
        rst_n = 1'b1;
        tick();

        // Single-block key
        start152(300'(K152), 1'b0, 1);
        @(negedge clk);
        chk("req152_first", 512'(bus152.hash_req), 1);
        chk("ct152_first", 512'(bus152.hash_msg[31:0]), 1);
        chk("z_capture", 512'(bus152.hash_msg[ZLEN+31:32]), 512'(zpat));
        chk("k152_busy_zero", 512'(bus152.k), 0);
        repeat (8) tick();
        chk("q152_drained_a", 512'(q152.size()), 0);

        // Two-block key
        zpat = {16{32'h0123_4567}};
        start300(K300, 1'b0, 1);
        @(negedge clk);
        chk("busy300", 512'(bus300.busy), 1);
        chk("k300_busy_zero", 512'(bus300.k), 0);
        repeat (8) tick();
        chk("q300_drained_a", 512'(q300.size()), 0);
        chk("k300_held", 512'(bus300.k), 512'(K300));

        // All-zero digests
        zero152 = 1;
        start152('0, 1'b1, 1);
        repeat (8) tick();
        zero152 = 0;
        chk("q152_drained_b", 512'(q152.size()), 0);

        // Abort in WAIT of block 2, then a late digest
        left300 = 1;
        start300('0, 1'b0, 0);
        repeat (4) tick();
        @(negedge clk);
        chk("abort_ct2", 512'(bus300.hash_msg[31:0]), 2);
        chk("abort_in_wait", 512'(bus300.hash_req), 0);
        tick();
        bus300.abort = 1'b1;
        tick();
        bus300.abort = 1'b0;
        stray300 = 1;
        tick();
        stray300 = 0;
        repeat (3) tick();
        @(negedge clk);
        chk("abort_busy", 512'(bus300.busy), 0);
        chk("abort_k", 512'(bus300.k), 0);
        chk("abort_kzero", 512'(bus300.k_zero), 0);
        left300 = 1000;
        tick();
        start300(K300, 1'b0, 1);
        repeat (8) tick();
        chk("q300_drained_b", 512'(q300.size()), 0);

        // Start while busy and stray digest in IDLE
        start152(300'(K152), 1'b0, 1);
        bus152.start = 1'b1;
        tick();
        tick();
        bus152.start = 1'b0;
        repeat (4) tick();
        stray152 = 1;
        tick();
        stray152 = 0;
        repeat (3) tick();
        @(negedge clk);
        chk("stray_k_held", 512'(bus152.k), 512'(K152));
        chk("stray_busy", 512'(bus152.busy), 0);
        chk("q152_drained_c", 512'(q152.size()), 0);

        // Asynchronous reset during WAIT
        left300 = 1;
        start300('0, 1'b0, 0);
        repeat (4) tick();
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 512'(bus300.busy), 0);
        chk("arst_hash_req", 512'(bus300.hash_req), 0);
        chk("arst_hash_msg", 512'(bus300.hash_msg), 0);
        chk("arst_k", 512'(bus300.k), 0);
        chk("arst_done", 512'(bus300.done), 0);
        chk("arst_k_zero", 512'(bus300.k_zero), 0);
        tick();
        rst_n = 1'b1;
        stray300 = 1;
        tick();
        stray300 = 0;
        repeat (3) tick();
        @(negedge clk);
        chk("post_rst_busy", 512'(bus300.busy), 0);
        left300 = 1000;
        tick();
        start300(K300, 1'b0, 1);
        repeat (8) tick();
        chk("q300_drained_c", 512'(q300.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
